// File: rtl/multiplier_if.sv
// Execute-stage multiply port bundle: core-side controls and operands in,
// selected product word and pipeline stall out.
interface multiplier_if #(
  parameter int unsigned XLEN = 32
);
  logic [2:0]      state_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            is_mul_i;
  logic            is_mulh_i;
  logic            is_mulhsu_i;
  logic            is_mulhu_i;
  logic [XLEN-1:0] writeback_val_o;
  logic            stall_ex_o;

  modport master (
    output state_i, op1_i, op2_i, is_mul_i, is_mulh_i, is_mulhsu_i, is_mulhu_i,
    input  writeback_val_o, stall_ex_o
  );

  modport slave (
    input  state_i, op1_i, op2_i, is_mul_i, is_mulh_i, is_mulhsu_i, is_mulhu_i,
    output writeback_val_o, stall_ex_o
  );
endinterface

// File: rtl/multiplier.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU. Multiplies
// operand magnitudes, then fixes the sign and selects the low or high word.
module multiplier #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned UNROLL     = 1,
  parameter logic [2:0]  EXECUTE_2  = 3'd3,
  parameter logic [2:0]  WRITE_BACK = 3'd4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  multiplier_if.slave  bus
);

  localparam int unsigned N  = XLEN / UNROLL;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_q, sel_hi_q;
  logic [XLEN-1:0]   result_q;

  logic              mul_en, in_exec, stall, start, finish;
  logic              op1_neg, op2_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] acc_step, mc_step, product;
  logic [XLEN-1:0]   mp_step;

  assign mul_en  = bus.is_mul_i | bus.is_mulh_i | bus.is_mulhsu_i | bus.is_mulhu_i;
  assign in_exec = (bus.state_i == EXECUTE_2);

  // Signed operands are reduced to magnitudes; 0x80000000 stays as an unsigned magnitude.
  assign op1_neg = (bus.is_mulh_i | bus.is_mulhsu_i) & bus.op1_i[XLEN-1];
  assign op2_neg = bus.is_mulh_i & bus.op2_i[XLEN-1];
  assign mag1    = op1_neg ? (~bus.op1_i + 1'b1) : bus.op1_i;
  assign mag2    = op2_neg ? (~bus.op2_i + 1'b1) : bus.op2_i;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_exec && mul_en) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!in_exec) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.state_i == WRITE_BACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplicand is shifted left once per step, equivalent to shifting by the bit index.
  always_comb begin
    acc_step = acc_q;
    mc_step  = mcand_q;
    mp_step  = mplier_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (mp_step[0]) acc_step = acc_step + mc_step;
      mc_step = mc_step << 1;
      mp_step = mp_step >> 1;
    end
    product = neg_q ? (~acc_step + 1'b1) : acc_step;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mcand_q  <= {{XLEN{1'b0}}, mag1};
        mplier_q <= mag2;
        acc_q    <= '0;
        cnt_q    <= '0;
        neg_q    <= op1_neg ^ op2_neg;
        sel_hi_q <= ~bus.is_mul_i;
      end else if (state_q == S_BUSY && in_exec) begin
        acc_q    <= acc_step;
        mcand_q  <= mc_step;
        mplier_q <= mp_step;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (finish) begin
        result_q <= sel_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
      end
    end
  end

  // Stall is combinational, so it is also gated by reset to drop without a clock.
  assign bus.stall_ex_o      = stall & rst_ni;
  assign bus.writeback_val_o = result_q;

endmodule
